// File: rtl/poly_drive_sequencer.sv
// rtl/poly_drive_sequencer.sv - replays the quadratic-evaluator load protocol for one operand set
//
// Accepts (a, b, c, x) over a valid/ready handshake, drives each operand onto
// data_out with a go pulse in the order A, B, C, X, waits out the core's
// compute time and returns the captured data_result over valid/ready.

module poly_drive_sequencer #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int CALC_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] x_in,
  output logic              go,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  // One down-counter serves hold, gap and compute waits, so size it for the longest.
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > CALC_CYCLES) ? MAX_HG : CALC_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CALC_LD = CNT_W'(CALC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HOLD,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [1:0]         idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]  op_a, op_b, op_c, op_x;
  logic [DATA_W-1:0]  data_out_n;
  logic [DATA_W-1:0]  result_n;
  logic               load_ops;

  // Operand selected by index: 0=A, 1=B, 2=C, 3=X.
  function automatic logic [DATA_W-1:0] pick(input logic [1:0]        i,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c,
                                             input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] v;
    case (i)
      2'd0:    v = a;
      2'd1:    v = b;
      2'd2:    v = c;
      default: v = x;
    endcase
    return v;
  endfunction

  // Handshake and strobe outputs decode straight from state, so reset clears go at once.
  assign in_ready  = (state == S_IDLE);
  assign go        = (state == S_HOLD);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // State register plus operand, data_out and result holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      op_x     <= '0;
      data_out <= '0;
      result   <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      data_out <= data_out_n;
      result   <= result_n;
      if (load_ops) begin
        op_a <= a_in;
        op_b <= b_in;
        op_c <= c_in;
        op_x <= x_in;
      end
    end
  end

  // Next-state logic; data_out is loaded on entry to SETUP and held through GAP
  // because the core samples data_in on the edge where go first rises.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    data_out_n = data_out;
    result_n   = result;
    load_ops   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          load_ops   = 1'b1;
          idx_n      = 2'd0;
          data_out_n = a_in;
          state_n    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_n   = HOLD_LD;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == CNT_ONE) begin
          cnt_n   = GAP_LD;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == CNT_ONE) begin
          if (idx == 2'd3) begin
            cnt_n      = CALC_LD;
            data_out_n = '0;
            state_n    = S_WAIT;
          end else begin
            idx_n      = idx + 2'd1;
            data_out_n = pick(idx + 2'd1, op_a, op_b, op_c, op_x);
            state_n    = S_SETUP;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_ONE) begin
          result_n = data_result;
          state_n  = S_DONE;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
